// File: rtl/hilo_ctrl_if.sv
// Datapath/unit-facing bundle for hilo_ctrl: issue request, mthi/mtlo, unit results and HI/LO view.
// Master side is the surrounding datapath plus multiply/divide unit; slave side is the controller.
interface hilo_ctrl_if;
    logic        start;
    logic        op_div;
    logic        op_signed;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        write_hi;
    logic        write_lo;
    logic [31:0] wdata;
    logic        rd_hi;
    logic [31:0] md_high;
    logic [31:0] md_low;
    logic        md_zero;

    logic        set_md;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] read_data;
    logic        busy;
    logic        done;
    logic        div_zero_exc;

    modport master (
        output start, op_div, op_signed, rs_data, rt_data,
        output write_hi, write_lo, wdata, rd_hi,
        output md_high, md_low, md_zero,
        input  set_md, data_a, data_b, hi, lo, read_data, busy, done, div_zero_exc
    );

    modport slave (
        input  start, op_div, op_signed, rs_data, rt_data,
        input  write_hi, write_lo, wdata, rd_hi,
        input  md_high, md_low, md_zero,
        output set_md, data_a, data_b, hi, lo, read_data, busy, done, div_zero_exc
    );
endinterface

// File: rtl/hilo_ctrl.sv
// Issue/commit controller for the mul/div unit; done pulses LATENCY+2 cycles after start.
// No queueing: start is only taken in IDLE, busy stalls the control FSM until commit.
module hilo_ctrl #(
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    hilo_ctrl_if.slave  bus
);

    localparam int CW = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          commit;

    logic [31:0]   data_a_q;
    logic [31:0]   data_b_q;
    logic          set_md_q;
    logic          neg_q;
    logic [31:0]   hi_q;
    logic [31:0]   lo_q;
    logic          busy_q;
    logic          done_q;
    logic          dz_q;

    logic          signed_mul;
    logic [31:0]   mag_a;
    logic [31:0]   mag_b;
    logic [63:0]   prod_raw;
    logic [63:0]   prod_fix;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                // Counter hits zero on this edge, so the unit outputs are valid next cycle.
                if (cnt <= CW'(1)) begin
                    state_nxt = COMMIT;
                end
            end
            COMMIT: begin
                commit    = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= CW'(LATENCY);
        end else if (state == WAIT && cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    // Signed multiply runs the unit unsigned on magnitudes; 0x80000000 maps to itself.
    always_comb begin
        signed_mul = !bus.op_div && bus.op_signed;
        mag_a      = bus.rs_data;
        mag_b      = bus.rt_data;
        if (signed_mul) begin
            mag_a = bus.rs_data[31] ? (~bus.rs_data + 32'd1) : bus.rs_data;
            mag_b = bus.rt_data[31] ? (~bus.rt_data + 32'd1) : bus.rt_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_a_q <= '0;
            data_b_q <= '0;
            set_md_q <= 1'b0;
            neg_q    <= 1'b0;
        end else if (accept) begin
            data_a_q <= mag_a;
            data_b_q <= mag_b;
            set_md_q <= bus.op_div;
            neg_q    <= signed_mul && (bus.rs_data[31] ^ bus.rt_data[31]);
        end
    end

    always_comb begin
        prod_raw = {bus.md_high, bus.md_low};
        prod_fix = neg_q ? (~prod_raw + 64'd1) : prod_raw;
    end

    // IDLE writes and an accepted start may coincide; the commit later overwrites.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (commit) begin
            if (!set_md_q) begin
                hi_q <= prod_fix[63:32];
                lo_q <= prod_fix[31:0];
            end else if (!bus.md_zero) begin
                hi_q <= bus.md_low;
                lo_q <= bus.md_high;
            end
        end else if (state == IDLE) begin
            if (bus.write_hi) begin
                hi_q <= bus.wdata;
            end
            if (bus.write_lo) begin
                lo_q <= bus.wdata;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            done_q <= commit;
            dz_q   <= commit && set_md_q && bus.md_zero;
            if (accept) begin
                busy_q <= 1'b1;
            end else if (commit) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign bus.set_md       = set_md_q;
    assign bus.data_a       = data_a_q;
    assign bus.data_b       = data_b_q;
    assign bus.hi           = hi_q;
    assign bus.lo           = lo_q;
    assign bus.read_data    = bus.rd_hi ? hi_q : lo_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.div_zero_exc = dz_q;

endmodule

// File: tb/tb_hilo_ctrl.sv
// Bench for hilo_ctrl with a behavioural mul/div unit and an expected-result queue.
module tb_hilo_ctrl;

    localparam int LAT = 1;

    logic clk;
    logic reset;
    hilo_ctrl_if bus ();

    hilo_ctrl #(.LATENCY(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural unit: unsigned product, or signed quotient/remainder with zero flag.
    logic [63:0]        unit_prod;
    logic signed [31:0] unit_q;
    logic signed [31:0] unit_r;
    always_comb begin
        unit_prod = {32'd0, bus.data_a} * {32'd0, bus.data_b};
        unit_q    = '0;
        unit_r    = '0;
        if (bus.data_b != 32'd0) begin
            unit_q = $signed(bus.data_a) / $signed(bus.data_b);
            unit_r = $signed(bus.data_a) % $signed(bus.data_b);
        end
        bus.md_zero = bus.set_md && (bus.data_b == 32'd0);
        bus.md_high = bus.set_md ? unit_q : unit_prod[63:32];
        bus.md_low  = bus.set_md ? unit_r : unit_prod[31:0];
    end

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model_hi;
    logic [31:0] model_lo;
    int          vectors;
    int          miscompares;

    function automatic logic [31:0] mag32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

    // Called positioned at a negedge; returns at the negedge of the done cycle.
    task automatic run_op(input logic div, input logic sgn, input logic [31:0] rs, input logic [31:0] rt,
                          input logic [31:0] exp_a, input logic [31:0] exp_b, input logic poke,
                          input string name);
        exp_t        e;
        exp_t        got;
        logic [63:0] p;
        int          k;
        int          busy_cycles;
        logic        seen;
        logic        hold_bad;
        if (div) begin
            if (rt == 32'd0) begin
                e.hi = model_hi;
                e.lo = model_lo;
                e.dz = 1'b1;
            end else begin
                e.lo = $signed(rs) / $signed(rt);
                e.hi = $signed(rs) % $signed(rt);
                e.dz = 1'b0;
            end
        end else begin
            if (sgn) p = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
            else     p = {32'd0, rs} * {32'd0, rt};
            e.hi = p[63:32];
            e.lo = p[31:0];
            e.dz = 1'b0;
        end
        sb_q.push_back(e);
        model_hi = e.hi;
        model_lo = e.lo;

        bus.start     = 1'b1;
        bus.op_div    = div;
        bus.op_signed = sgn;
        bus.rs_data   = rs;
        bus.rt_data   = rt;
        seen        = 1'b0;
        hold_bad    = 1'b0;
        busy_cycles = 0;
        k           = 0;
        while (!seen && k < 20) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                bus.start = 1'b0;
                if (poke) begin
                    bus.start     = 1'b1;
                    bus.op_div    = ~div;
                    bus.op_signed = 1'b1;
                    bus.rs_data   = 32'h0000_0003;
                    bus.rt_data   = 32'h0000_0009;
                    bus.write_hi  = 1'b1;
                    bus.write_lo  = 1'b1;
                    bus.wdata     = 32'hDEAD_BEEF;
                end
            end else if (k == 2) begin
                bus.start    = 1'b0;
                bus.write_hi = 1'b0;
                bus.write_lo = 1'b0;
            end
            if (bus.done) begin
                seen = 1'b1;
            end else if (bus.busy) begin
                busy_cycles++;
                if (bus.set_md !== div || bus.data_a !== exp_a || bus.data_b !== exp_b) hold_bad = 1'b1;
            end
        end
        bus.start    = 1'b0;
        bus.write_hi = 1'b0;
        bus.write_lo = 1'b0;

        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL %s done_timeout: no done within %0d cycles", name, k);
            void'(sb_q.pop_front());
        end else begin
            got = sb_q.pop_front();
            if (k !== LAT + 2) begin
                miscompares++;
                $display("FAIL %s done_latency: got %0d want %0d", name, k, LAT + 2);
            end
            vectors++;
            if (busy_cycles !== LAT + 1) begin
                miscompares++;
                $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_cycles, LAT + 1);
            end
            vectors++;
            if (hold_bad) begin
                miscompares++;
                $display("FAIL %s operand_hold: data_a/data_b/set_md moved or wrong, want a=%h b=%h md=%0b",
                         name, exp_a, exp_b, div);
            end
            vectors++;
            if (bus.hi !== got.hi || bus.lo !== got.lo) begin
                miscompares++;
                $display("FAIL %s hilo: got %h_%h want %h_%h", name, bus.hi, bus.lo, got.hi, got.lo);
            end
            vectors++;
            if (bus.div_zero_exc !== got.dz || bus.busy !== 1'b0) begin
                miscompares++;
                $display("FAIL %s dz_busy: got dz=%0b busy=%0b want dz=%0b busy=0",
                         name, bus.div_zero_exc, bus.busy, got.dz);
            end
        end
    endtask

    task automatic check_pulse_end(input string name);
        @(negedge clk);
        vectors++;
        if (bus.done !== 1'b0 || bus.div_zero_exc !== 1'b0) begin
            miscompares++;
            $display("FAIL %s pulse_width: got done=%0b dz=%0b want 0 0", name, bus.done, bus.div_zero_exc);
        end
    endtask

    task automatic test_reset();
        vectors++;
        if (bus.hi !== 32'd0 || bus.lo !== 32'd0 || bus.data_a !== 32'd0 || bus.data_b !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_data: got hi=%h lo=%h a=%h b=%h want all 0", bus.hi, bus.lo, bus.data_a, bus.data_b);
        end
        vectors++;
        if ({bus.set_md, bus.busy, bus.done, bus.div_zero_exc} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got md/busy/done/dz=%b want 0000",
                     {bus.set_md, bus.busy, bus.done, bus.div_zero_exc});
        end
    endtask

    task automatic test_mul_unsigned();
        run_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, "mulu");
        check_pulse_end("mulu");
    endtask

    task automatic test_mul_signed();
        logic [31:0] a;
        logic [31:0] b;
        run_op(1'b0, 1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 32'd3, 32'd5, 1'b0, "muls_m3x5");
        check_pulse_end("muls_m3x5");
        run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 1'b0, "muls_min");
        check_pulse_end("muls_min");
        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            b = $urandom;
            run_op(1'b0, 1'b1, a, b, mag32(a), mag32(b), 1'b0, "muls_rand");
            check_pulse_end("muls_rand");
        end
    endtask

    task automatic test_div();
        run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFE, 32'd7, 32'hFFFF_FFFE, 1'b0, "div_7_m2");
        check_pulse_end("div_7_m2");
        vectors++;
        if (bus.hi !== 32'h0000_0001 || bus.lo !== 32'hFFFF_FFFD) begin
            miscompares++;
            $display("FAIL div_7_m2 const: got %h_%h want 00000001_fffffffd", bus.hi, bus.lo);
        end
    endtask

    task automatic test_div_zero();
        run_op(1'b1, 1'b1, 32'd100, 32'd0, 32'd100, 32'd0, 1'b0, "div_zero");
        check_pulse_end("div_zero");
    endtask

    task automatic test_start_while_busy();
        int extra;
        run_op(1'b1, 1'b0, 32'd9, 32'd0, 32'd9, 32'd0, 1'b1, "busy_ignore");
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) extra++;
        end
        vectors++;
        if (extra !== 0) begin
            miscompares++;
            $display("FAIL busy_ignore extra_activity: got %0d cycles with done/busy want 0", extra);
        end
        bus.write_hi = 1'b1;
        bus.wdata    = 32'h1234_5678;
        @(negedge clk);
        bus.write_hi = 1'b0;
        bus.write_lo = 1'b1;
        bus.wdata    = 32'hCAFE_0001;
        bus.rd_hi    = 1'b1;
        #1;
        vectors++;
        if (bus.hi !== 32'h1234_5678 || bus.read_data !== 32'h1234_5678) begin
            miscompares++;
            $display("FAIL mthi: got hi=%h rd=%h want 12345678", bus.hi, bus.read_data);
        end
        @(negedge clk);
        bus.write_lo = 1'b0;
        bus.rd_hi    = 1'b0;
        #1;
        vectors++;
        if (bus.lo !== 32'hCAFE_0001 || bus.read_data !== 32'hCAFE_0001) begin
            miscompares++;
            $display("FAIL mtlo: got lo=%h rd=%h want cafe0001", bus.lo, bus.read_data);
        end
        model_hi = 32'h1234_5678;
        model_lo = 32'hCAFE_0001;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        run_op(1'b0, 1'b0, 32'd3, 32'd4, 32'd3, 32'd4, 1'b0, "b2b_first");
        bus.rd_hi = 1'b0;
        #1;
        vectors++;
        if (bus.read_data !== 32'd12) begin
            miscompares++;
            $display("FAIL b2b_read_done_cycle: got %h want 0000000c", bus.read_data);
        end
        run_op(1'b0, 1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd1, 1'b0, "b2b_second");
        check_pulse_end("b2b_second");
    endtask

    task automatic test_reset_mid_wait();
        int dones;
        bus.start     = 1'b1;
        bus.op_div    = 1'b0;
        bus.op_signed = 1'b0;
        bus.rs_data   = 32'hFFFF_FFFF;
        bus.rt_data   = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.start = 1'b0;
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_mid_wait: got busy=%0b hi=%h lo=%h want 0 0 0", bus.busy, bus.hi, bus.lo);
        end
        @(negedge clk);
        reset = 1'b0;
        model_hi = 32'd0;
        model_lo = 32'd0;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        vectors++;
        if (dones !== 0) begin
            miscompares++;
            $display("FAIL reset_no_done: got %0d done pulses want 0", dones);
        end
        run_op(1'b1, 1'b0, 32'hFFFF_FFF0, 32'd3, 32'hFFFF_FFF0, 32'd3, 1'b0, "after_reset");
        check_pulse_end("after_reset");
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        model_hi     = '0;
        model_lo     = '0;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.op_div   = 1'b0;
        bus.op_signed = 1'b0;
        bus.rs_data  = '0;
        bus.rt_data  = '0;
        bus.write_hi = 1'b0;
        bus.write_lo = 1'b0;
        bus.wdata    = '0;
        bus.rd_hi    = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        reset = 1'b0;
        @(negedge clk);
        test_mul_unsigned();
        test_mul_signed();
        test_div();
        test_div_zero();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
